// File: rtl/dmi_pkg.sv
// Shared encodings for the DMI command master: DMI ops, DMI responses,
// host-side response status codes and the request-engine state.
package dmi_pkg;
    localparam logic [1:0] OP_NOP   = 2'd0;
    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;
    localparam logic [1:0] RESP_BUSY = 2'd3;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_FAILED   = 2'd2;
    localparam logic [1:0] ST_BUSY_EXH = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_GAP} state_t;
endpackage

// File: rtl/dmi_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; no fall-through, so a push
// becomes visible at the head one cycle later.
module dmi_rsp_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          full, empty, do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A pop frees the slot being written when full, so both may proceed.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign head    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/dmi_cmd_master.sv
// DMI request engine: issues one host command at a time, retries busy
// responses, times out hung transfers, buffers results and latches an exit code.
module dmi_cmd_master
    import dmi_pkg::*;
#(
    parameter int          ADDR_W    = 7,
    parameter int          DATA_W    = 32,
    parameter int          RSP_DEPTH = 4,
    parameter int          TIMEOUT   = 1024,
    parameter int          MAX_RETRY = 8,
    parameter int          RETRY_GAP = 4,
    parameter int unsigned EXIT_ADDR = 'h7f
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [1:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_status,
    output logic              debug_req_valid,
    input  logic              debug_req_ready,
    output logic [ADDR_W-1:0] debug_req_bits_addr,
    output logic [1:0]        debug_req_bits_op,
    output logic [DATA_W-1:0] debug_req_bits_data,
    input  logic              debug_resp_valid,
    output logic              debug_resp_ready,
    input  logic [1:0]        debug_resp_bits_resp,
    input  logic [DATA_W-1:0] debug_resp_bits_data,
    output logic [31:0]       exit,
    output logic              busy
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GW = $clog2(RETRY_GAP + 1);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    localparam logic [TW-1:0]     TO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [GW-1:0]     GAP_LAST  = GW'(RETRY_GAP - 1);
    localparam logic [ADDR_W-1:0] EXIT_A    = ADDR_W'(EXIT_ADDR);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   req_addr, req_addr_n;
    logic [1:0]          req_op, req_op_n;
    logic [DATA_W-1:0]   req_data, req_data_n;
    logic [RW-1:0]       retry_cnt, retry_n;
    logic [TW-1:0]       timer, timer_n;
    logic [GW-1:0]       gap_cnt, gap_n;
    logic                drain, drain_n;
    logic [31:0]         exit_n;
    logic                started;
    logic                cmd_fire, req_fire, resp_fire;
    logic                push;
    logic [DATA_W+1:0]   push_data;
    logic [CW-1:0]       fifo_count;

    // Result space is reserved at accept, so a completion can always push.
    assign cmd_ready = started && (state == S_IDLE) && (fifo_count < CW'(RSP_DEPTH));
    assign rsp_valid = (fifo_count != '0);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign req_fire  = debug_req_valid && debug_req_ready;
    assign resp_fire = debug_resp_valid && debug_resp_ready;

    assign debug_req_bits_addr = req_addr;
    assign debug_req_bits_op   = req_op;
    assign debug_req_bits_data = req_data;

    always_comb begin
        state_n    = state;
        req_addr_n = req_addr;
        req_op_n   = req_op;
        req_data_n = req_data;
        retry_n    = retry_cnt;
        timer_n    = timer;
        gap_n      = gap_cnt;
        drain_n    = drain;
        exit_n     = exit;
        push       = 1'b0;
        push_data  = {{DATA_W{1'b0}}, ST_OK};

        // The first response seen after a timeout belongs to the abandoned transfer.
        if (drain && resp_fire) drain_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_op == OP_READ || cmd_op == OP_WRITE) begin
                        req_addr_n = cmd_addr;
                        req_op_n   = cmd_op;
                        req_data_n = cmd_data;
                        retry_n    = '0;
                        state_n    = S_REQ;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (req_fire) begin
                    timer_n = '0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (timer != TO_LAST) timer_n = timer + 1'b1;
                if (resp_fire) begin
                    state_n = S_IDLE;
                    case (debug_resp_bits_resp)
                        RESP_OK: begin
                            push = 1'b1;
                            if (req_op == OP_READ)
                                push_data = {debug_resp_bits_data, ST_OK};
                            if (req_op == OP_WRITE && req_addr == EXIT_A && !exit[0])
                                exit_n = {req_data[31:1], 1'b1};
                        end
                        RESP_BUSY: begin
                            if (retry_cnt < RETRY_MAX) begin
                                retry_n = retry_cnt + 1'b1;
                                gap_n   = '0;
                                state_n = S_GAP;
                            end else begin
                                push      = 1'b1;
                                push_data = {{DATA_W{1'b0}}, ST_BUSY_EXH};
                            end
                        end
                        default: begin
                            push      = 1'b1;
                            push_data = {{DATA_W{1'b0}}, ST_FAILED};
                        end
                    endcase
                end else if (timer == TO_LAST) begin
                    push      = 1'b1;
                    push_data = {{DATA_W{1'b0}}, ST_TIMEOUT};
                    drain_n   = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_n = S_REQ;
                else                     gap_n   = gap_cnt + 1'b1;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            req_addr         <= '0;
            req_op           <= '0;
            req_data         <= '0;
            retry_cnt        <= '0;
            timer            <= '0;
            gap_cnt          <= '0;
            drain            <= 1'b0;
            exit             <= '0;
            started          <= 1'b0;
            debug_req_valid  <= 1'b0;
            debug_resp_ready <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_n;
            req_addr         <= req_addr_n;
            req_op           <= req_op_n;
            req_data         <= req_data_n;
            retry_cnt        <= retry_n;
            timer            <= timer_n;
            gap_cnt          <= gap_n;
            drain            <= drain_n;
            exit             <= exit_n;
            started          <= 1'b1;
            // Handshake outputs are registered from next-state values.
            debug_req_valid  <= (state_n == S_REQ) && !drain_n;
            debug_resp_ready <= (state_n == S_WAIT) || drain_n;
            busy             <= (state_n != S_IDLE);
        end
    end

    dmi_rsp_fifo #(.W(DATA_W + 2), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (push_data),
        .pop       (rsp_ready),
        .head      ({rsp_data, rsp_status}),
        .count     (fifo_count)
    );
endmodule

// File: tb/tb_dmi_cmd_master.sv
// Directed bench for dmi_cmd_master: reads, busy retries, timeout with drain,
// FIFO back-pressure, exit latching and mid-transfer reset.
module tb_dmi_cmd_master;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [6:0]  cmd_addr = '0;
    logic [1:0]  cmd_op = '0;
    logic [31:0] cmd_data = '0;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        debug_req_valid, debug_req_ready = 1'b0;
    logic [6:0]  debug_req_bits_addr;
    logic [1:0]  debug_req_bits_op;
    logic [31:0] debug_req_bits_data;
    logic        debug_resp_valid = 1'b0, debug_resp_ready;
    logic [1:0]  debug_resp_bits_resp = '0;
    logic [31:0] debug_resp_bits_data = '0;
    logic [31:0] exit;
    logic        busy;

    int n_tests = 0, n_fail = 0, cyc = 0;

    dmi_cmd_master #(.ADDR_W(7), .DATA_W(32), .RSP_DEPTH(4), .TIMEOUT(16),
                     .MAX_RETRY(8), .RETRY_GAP(4), .EXIT_ADDR('h7f)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .debug_req_valid(debug_req_valid), .debug_req_ready(debug_req_ready),
        .debug_req_bits_addr(debug_req_bits_addr), .debug_req_bits_op(debug_req_bits_op),
        .debug_req_bits_data(debug_req_bits_data),
        .debug_resp_valid(debug_resp_valid), .debug_resp_ready(debug_resp_ready),
        .debug_resp_bits_resp(debug_resp_bits_resp), .debug_resp_bits_data(debug_resp_bits_data),
        .exit(exit), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
        int n = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        while (cmd_ready !== 1'b1 && n < 100) begin tick(); n++; end
        chk("cmd_accept", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_req_hs(output int hs);
        int n = 0;
        while (debug_req_valid !== 1'b1 && n < 100) begin tick(); n++; end
        chk("req_valid_seen", debug_req_valid, 1);
        debug_req_ready = 1'b1;
        tick();
        debug_req_ready = 1'b0;
        hs = cyc;
    endtask

    task automatic respond(input logic [1:0] resp, input logic [31:0] data);
        chk("resp_ready", debug_resp_ready, 1);
        debug_resp_valid = 1'b1; debug_resp_bits_resp = resp; debug_resp_bits_data = data;
        tick();
        debug_resp_valid = 1'b0;
    endtask

    task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                          input logic [1:0] resp, input logic [31:0] rdata);
        int hs;
        send_cmd(op, addr, data);
        do_req_hs(hs);
        respond(resp, rdata);
    endtask

    task automatic pop_rsp(input string tag, input logic [31:0] d, input logic [1:0] st);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin tick(); n++; end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_data"}, rsp_data, d);
        chk({tag, "_status"}, rsp_status, st);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int hs, last, n;

        // Reset state
        tick(); tick();
        chk("rst_req_valid", debug_req_valid, 0);
        chk("rst_resp_ready", debug_resp_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_exit", exit, 0);
        reset_n = 1'b1;
        chk("first_cycle_cmd_ready", cmd_ready, 0);
        tick();
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Read 0x11, reply 0xDEADBEEF three cycles after the handshake
        send_cmd(2'd1, 7'h11, 32'h0);
        chk("rd_req_valid", debug_req_valid, 1);
        chk("rd_req_addr", debug_req_bits_addr, 7'h11);
        chk("rd_req_op", debug_req_bits_op, 2'd1);
        chk("rd_busy", busy, 1);
        do_req_hs(hs);
        tick(); tick();
        chk("rd_busy_before_push", busy, 1);
        respond(2'd0, 32'hDEADBEEF);
        chk("rd_busy_after_push", busy, 0);
        chk("rd_rsp_valid", rsp_valid, 1);
        pop_rsp("rd", 32'hDEADBEEF, 2'd0);

        // Write with three busy replies then ok; handshake, busy reply, 4 gap
        // cycles, then a fresh REQ cycle puts handshakes 6 cycles apart.
        send_cmd(2'd2, 7'h05, 32'h1234);
        last = 0;
        for (int i = 0; i < 4; i++) begin
            do_req_hs(hs);
            chk("retry_data", debug_req_bits_data, 32'h1234);
            if (i > 0) chk("retry_spacing", hs - last, 6);
            last = hs;
            respond((i < 3) ? 2'd3 : 2'd0, 32'h0);
        end
        pop_rsp("wr_retry", 32'h0, 2'd0);

        // Busy on every attempt: 1 + 8 retries, then busy-exhausted
        send_cmd(2'd2, 7'h06, 32'h77);
        for (int i = 0; i < 9; i++) begin
            do_req_hs(hs);
            respond(2'd3, 32'h0);
        end
        pop_rsp("busy_exh", 32'h0, 2'd3);

        // Read answered with resp=1 reports failed
        do_txn(2'd1, 7'h07, 32'h0, 2'd1, 32'h0);
        pop_rsp("resp1_fail", 32'h0, 2'd2);

        // Timeout, then late response absorbed by drain
        send_cmd(2'd1, 7'h22, 32'h0);
        do_req_hs(hs);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin tick(); n++; end
        chk("to_latency", cyc - hs, 16);
        chk("to_drain_resp_ready", debug_resp_ready, 1);
        chk("to_busy", busy, 0);
        pop_rsp("timeout", 32'h0, 2'd1);
        while (cyc < hs + 19) tick();
        respond(2'd0, 32'hBAD);
        chk("late_absorbed", rsp_valid, 0);
        chk("drain_cleared", debug_resp_ready, 0);
        do_txn(2'd1, 7'h33, 32'h0, 2'd0, 32'h77);
        pop_rsp("after_drain", 32'h77, 2'd0);

        // FIFO back-pressure: 4 entries, 5th command held until a pop
        do_txn(2'd1, 7'h44, 32'h0, 2'd0, 32'h111);
        send_cmd(2'd0, 7'h0, 32'h0);
        send_cmd(2'd3, 7'h0, 32'h0);
        send_cmd(2'd0, 7'h0, 32'h0);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 7'h55; cmd_data = 32'h0;
        chk("full_cmd_ready", cmd_ready, 0);
        tick();
        chk("full_cmd_ready_hold", cmd_ready, 0);
        chk("full_not_busy", busy, 0);
        pop_rsp("fifo0", 32'h111, 2'd0);
        chk("space_cmd_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        do_req_hs(hs);
        respond(2'd0, 32'h555);
        pop_rsp("fifo1", 32'h0, 2'd0);
        pop_rsp("fifo2", 32'h0, 2'd0);
        pop_rsp("fifo3", 32'h0, 2'd0);
        pop_rsp("fifo4", 32'h555, 2'd0);
        chk("fifo_empty", rsp_valid, 0);

        // Exit latching: failed write ignored, first ok write latches, sticky
        do_txn(2'd2, 7'h7f, 32'h99, 2'd2, 32'h0);
        chk("exit_after_fail", exit, 32'h0);
        pop_rsp("exit_fail", 32'h0, 2'd2);
        do_txn(2'd2, 7'h7f, 32'h2A, 2'd0, 32'h0);
        chk("exit_latched", exit, 32'h2B);
        pop_rsp("exit_wr", 32'h0, 2'd0);
        do_txn(2'd2, 7'h7f, 32'h10, 2'd0, 32'h0);
        chk("exit_sticky", exit, 32'h2B);
        pop_rsp("exit_wr2", 32'h0, 2'd0);

        // Reset asserted mid-WAIT with a pending response in the FIFO
        send_cmd(2'd0, 7'h0, 32'h0);
        send_cmd(2'd1, 7'h66, 32'h0);
        do_req_hs(hs);
        tick();
        chk("pre_rst_resp_ready", debug_resp_ready, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", debug_req_valid, 0);
        chk("mid_rst_resp_ready", debug_resp_ready, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_exit", exit, 32'h0);
        chk("mid_rst_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_busy", busy, 0);
        send_cmd(2'd0, 7'h0, 32'h0);
        pop_rsp("post_rst_nop", 32'h0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
